// File: rtl/sram_ctrl_pkg.sv
// Shared types and limits for the SRAM access controller.
// Imported by the controller top and its address counter.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WRITE,
        ST_INCADDR
    } sram_state_e;

    localparam int SRAM_ADDR_W_DEF = 19;
    localparam int SRAM_DATA_W_DEF = 8;
    localparam int WE_CYCLES_MAX   = 15;
    localparam int WE_CNT_W        = $clog2(WE_CYCLES_MAX + 1);

    // Preset for the WRITE-phase down counter, clamped into the legal range.
    function automatic logic [WE_CNT_W-1:0] we_preset(input int cycles);
        int c;
        c = cycles;
        if (c < 1) c = 1;
        if (c > WE_CYCLES_MAX) c = WE_CYCLES_MAX;
        return WE_CNT_W'(c - 1);
    endfunction

endpackage

// File: rtl/sram_addr_counter.sv
// SRAM address counter: load, increment, wrap or saturate.
// Produces the sticky FULL flag and the EMPTY status.
module sram_addr_counter
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = SRAM_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_val,
    input  logic                  inc_en,
    input  logic                  wrap_en,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  full,
    output logic                  empty
);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  full_q, full_d;

    always_comb begin
        addr_d = addr_q;
        full_d = full_q;
        if (load_en) begin
            addr_d = load_val;
            full_d = 1'b0;
        end else if (inc_en) begin
            if (addr_q == {ADDR_WIDTH{1'b1}}) begin
                if (wrap_en) addr_d = '0;
                else         full_d = 1'b1;
            end else begin
                addr_d = addr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            full_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            full_q <= full_d;
        end
    end

    assign addr  = addr_q;
    assign full  = full_q;
    assign empty = (addr_q == '0) && !full_q;

endmodule

// File: rtl/sram_access_ctrl.sv
// Multi-channel SRAM write controller with a shared address counter.
// Requests are latched as pending bits and serviced one per idle cycle.
module sram_access_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = SRAM_ADDR_W_DEF,
    parameter int DATA_WIDTH = SRAM_DATA_W_DEF,
    parameter int NUM_CH     = 2,
    parameter int WE_CYCLES  = 1
) (
    input  logic                         CLOCK,
    input  logic                         RESET_n,
    input  logic [NUM_CH-1:0]            WR_REQ,
    input  logic [NUM_CH*DATA_WIDTH-1:0] WR_DATA,
    output logic [NUM_CH-1:0]            WR_ACK,
    input  logic                         RD_INC,
    input  logic                         ADDR_LOAD,
    input  logic [ADDR_WIDTH-1:0]        ADDR_LOAD_VAL,
    input  logic                         WRAP_EN,
    output logic [ADDR_WIDTH-1:0]        SRAM_A,
    output logic [DATA_WIDTH-1:0]        SRAM_DQ_OUT,
    output logic                         SRAM_WE_n,
    output logic                         SRAM_OE_n,
    output logic                         BUSY,
    output logic                         EMPTY,
    output logic                         FULL,
    output logic                         OVERRUN
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // Assert asynchronously, release two clocks after RESET_n rises.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n;

    assign rst_sync_d = {rst_sync_q[0], 1'b1};

    always_ff @(posedge CLOCK or negedge RESET_n) begin
        if (!RESET_n) rst_sync_q <= '0;
        else          rst_sync_q <= rst_sync_d;
    end

    assign rst_n = rst_sync_q[1];

    sram_state_e state_q, state_d;
    logic [WE_CNT_W-1:0] cnt_q, cnt_d;
    logic [CH_W-1:0]     sel_q, sel_d;
    logic [DATA_WIDTH-1:0] dq_q, dq_d;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] hold_q, hold_d;
    logic [NUM_CH-1:0]   wr_pend_q, wr_pend_d;
    logic [NUM_CH-1:0]   ack_q, ack_d;
    logic [ADDR_WIDTH-1:0] ld_val_q, ld_val_d;
    logic ld_pend_q, ld_pend_d;
    logic inc_pend_q, inc_pend_d;
    logic ovr_q, ovr_d;
    logic we_n_q, we_n_d;
    logic oe_n_q, oe_n_d;
    logic busy_q, busy_d;

    logic            addr_load_en;
    logic            addr_inc_en;
    logic            cnt_full;
    logic [CH_W-1:0] first_ch;

    always_comb begin
        first_ch = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (wr_pend_q[c]) first_ch = CH_W'(c);
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        dq_d         = dq_q;
        hold_d       = hold_q;
        wr_pend_d    = wr_pend_q;
        ack_d        = '0;
        ld_val_d     = ld_val_q;
        ld_pend_d    = ld_pend_q;
        inc_pend_d   = inc_pend_q;
        ovr_d        = ovr_q;
        addr_load_en = 1'b0;
        addr_inc_en  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (ld_pend_q) begin
                    addr_load_en = 1'b1;
                    ld_pend_d    = 1'b0;
                    ovr_d        = 1'b0;
                end else if (inc_pend_q) begin
                    addr_inc_en = 1'b1;
                    inc_pend_d  = 1'b0;
                end else if (|wr_pend_q) begin
                    sel_d   = first_ch;
                    dq_d    = hold_q[first_ch];
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                // A saturated, non-wrapping counter drops the write.
                if (cnt_full && !WRAP_EN) begin
                    ovr_d            = 1'b1;
                    ack_d[sel_q]     = 1'b1;
                    wr_pend_d[sel_q] = 1'b0;
                    state_d          = ST_INCADDR;
                end else begin
                    cnt_d   = we_preset(WE_CYCLES);
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (cnt_q == '0) begin
                    ack_d[sel_q]     = 1'b1;
                    wr_pend_d[sel_q] = 1'b0;
                    state_d          = ST_INCADDR;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_INCADDR: begin
                if (ld_pend_q) begin
                    addr_load_en = 1'b1;
                    ld_pend_d    = 1'b0;
                    ovr_d        = 1'b0;
                end else begin
                    addr_inc_en = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        for (int c = 0; c < NUM_CH; c++) begin
            if (WR_REQ[c]) begin
                if (wr_pend_q[c]) ovr_d = 1'b1;
                wr_pend_d[c] = 1'b1;
                hold_d[c]    = WR_DATA[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        if (ADDR_LOAD && !ld_pend_q) begin
            ld_pend_d = 1'b1;
            ld_val_d  = ADDR_LOAD_VAL;
        end
        if (RD_INC) inc_pend_d = 1'b1;

        we_n_d = (state_d != ST_WRITE);
        oe_n_d = (state_d == ST_SETUP) || (state_d == ST_WRITE);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sel_q      <= '0;
            dq_q       <= '0;
            hold_q     <= '0;
            wr_pend_q  <= '0;
            ack_q      <= '0;
            ld_val_q   <= '0;
            ld_pend_q  <= 1'b0;
            inc_pend_q <= 1'b0;
            ovr_q      <= 1'b0;
            we_n_q     <= 1'b1;
            oe_n_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            dq_q       <= dq_d;
            hold_q     <= hold_d;
            wr_pend_q  <= wr_pend_d;
            ack_q      <= ack_d;
            ld_val_q   <= ld_val_d;
            ld_pend_q  <= ld_pend_d;
            inc_pend_q <= inc_pend_d;
            ovr_q      <= ovr_d;
            we_n_q     <= we_n_d;
            oe_n_q     <= oe_n_d;
            busy_q     <= busy_d;
        end
    end

    sram_addr_counter #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_addr_cnt (
        .clk     (CLOCK),
        .rst_n   (rst_n),
        .load_en (addr_load_en),
        .load_val(ld_val_q),
        .inc_en  (addr_inc_en),
        .wrap_en (WRAP_EN),
        .addr    (SRAM_A),
        .full    (cnt_full),
        .empty   (EMPTY)
    );

    assign FULL        = cnt_full;
    assign OVERRUN     = ovr_q;
    assign WR_ACK      = ack_q;
    assign SRAM_DQ_OUT = dq_q;
    assign SRAM_WE_n   = we_n_q;
    assign SRAM_OE_n   = oe_n_q;
    assign BUSY        = busy_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Self-checking bench for sram_access_ctrl with directed and random tests.
// A transaction-level model predicts address, flags and the SRAM write log.
module tb_sram_access_ctrl;

    localparam int AW = 19;
    localparam int DW = 8;
    localparam int NC = 2;
    localparam int WE = 2;
    localparam logic [AW-1:0] AMAX = {AW{1'b1}};

    logic          CLOCK = 1'b0;
    logic          RESET_n = 1'b0;
    logic [NC-1:0] WR_REQ = '0;
    logic [NC*DW-1:0] WR_DATA = '0;
    logic [NC-1:0] WR_ACK;
    logic          RD_INC = 1'b0;
    logic          ADDR_LOAD = 1'b0;
    logic [AW-1:0] ADDR_LOAD_VAL = '0;
    logic          WRAP_EN = 1'b0;
    logic [AW-1:0] SRAM_A;
    logic [DW-1:0] SRAM_DQ_OUT;
    logic          SRAM_WE_n, SRAM_OE_n, BUSY, EMPTY, FULL, OVERRUN;

    sram_access_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CH(NC), .WE_CYCLES(WE)
    ) dut (
        .CLOCK(CLOCK), .RESET_n(RESET_n), .WR_REQ(WR_REQ), .WR_DATA(WR_DATA),
        .WR_ACK(WR_ACK), .RD_INC(RD_INC), .ADDR_LOAD(ADDR_LOAD),
        .ADDR_LOAD_VAL(ADDR_LOAD_VAL), .WRAP_EN(WRAP_EN), .SRAM_A(SRAM_A),
        .SRAM_DQ_OUT(SRAM_DQ_OUT), .SRAM_WE_n(SRAM_WE_n), .SRAM_OE_n(SRAM_OE_n),
        .BUSY(BUSY), .EMPTY(EMPTY), .FULL(FULL), .OVERRUN(OVERRUN)
    );

    always #5 CLOCK = ~CLOCK;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            len;
    } wr_t;

    wr_t wlog[$];
    int  ackq[$];
    int  we_run = 0;
    int  unstable = 0;
    logic [AW-1:0] cap_a;
    logic [DW-1:0] cap_d;

    // Bus monitor: records each WE_n low pulse and every WR_ACK.
    always @(negedge CLOCK) begin
        if (SRAM_WE_n === 1'b0) begin
            if (we_run == 0) begin
                cap_a = SRAM_A;
                cap_d = SRAM_DQ_OUT;
            end else if (SRAM_A !== cap_a || SRAM_DQ_OUT !== cap_d) begin
                unstable++;
            end
            we_run++;
        end else if (we_run != 0) begin
            wlog.push_back('{a: cap_a, d: cap_d, len: we_run});
            we_run = 0;
        end
        for (int c = 0; c < NC; c++) if (WR_ACK[c] === 1'b1) ackq.push_back(c);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    task automatic clr_logs();
        wlog.delete();
        ackq.delete();
    endtask

    task automatic pulse_load(input logic [AW-1:0] v);
        @(negedge CLOCK);
        ADDR_LOAD = 1'b1;
        ADDR_LOAD_VAL = v;
        @(negedge CLOCK);
        ADDR_LOAD = 1'b0;
    endtask

    task automatic pulse_inc();
        @(negedge CLOCK);
        RD_INC = 1'b1;
        @(negedge CLOCK);
        RD_INC = 1'b0;
    endtask

    task automatic pulse_wr(input int ch, input logic [DW-1:0] d);
        @(negedge CLOCK);
        WR_REQ[ch] = 1'b1;
        WR_DATA[ch*DW +: DW] = d;
        @(negedge CLOCK);
        WR_REQ = '0;
    endtask

    task automatic test_reset();
        RESET_n = 1'b0;
        wait_cyc(3);
        RESET_n = 1'b1;
        wait_cyc(4);
        checks++;
        if ({SRAM_A, SRAM_DQ_OUT, SRAM_WE_n, SRAM_OE_n, WR_ACK, BUSY, FULL, OVERRUN, EMPTY}
            !== {{AW{1'b0}}, {DW{1'b0}}, 1'b1, 1'b0, {NC{1'b0}}, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_state: A=%h DQ=%h WE=%b OE=%b ACK=%b BUSY=%b FULL=%b OVR=%b EMPTY=%b",
                     SRAM_A, SRAM_DQ_OUT, SRAM_WE_n, SRAM_OE_n, WR_ACK, BUSY, FULL, OVERRUN, EMPTY);
        end
    endtask

    task automatic test_single_write();
        logic [4:0] got, exp;
        WRAP_EN = 1'b1;
        pulse_load(19'h00010);
        wait_cyc(3);
        clr_logs();
        @(negedge CLOCK);
        WR_REQ[0] = 1'b1;
        WR_DATA[7:0] = 8'hA5;
        for (int i = 0; i <= 5; i++) begin
            @(negedge CLOCK);
            WR_REQ = '0;
            got = {SRAM_WE_n, SRAM_OE_n, WR_ACK[0], BUSY, SRAM_A == (i == 5 ? 19'h00011 : 19'h00010)};
            unique case (i)
                0: exp = 5'b10001;
                1: exp = 5'b11011;
                2, 3: exp = 5'b01011;
                4: exp = 5'b10111;
                default: exp = 5'b10001;
            endcase
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL single_write_k+%0d: {WE,OE,ACK,BUSY,Aok}=%b want %b A=%h", i, got, exp, SRAM_A);
            end
            if (i == 1) begin
                checks++;
                if (SRAM_DQ_OUT !== 8'hA5) begin
                    failures++;
                    $display("FAIL setup_dq: got %h want a5", SRAM_DQ_OUT);
                end
            end
        end
        checks++;
        if (wlog.size() != 1 || wlog[0].a !== 19'h00010 || wlog[0].d !== 8'hA5 || wlog[0].len != WE) begin
            failures++;
            $display("FAIL single_write_log: entries=%0d a=%h d=%h len=%0d want 1 00010 a5 %0d",
                     wlog.size(), wlog.size() ? wlog[0].a : 'x, wlog.size() ? wlog[0].d : 'x,
                     wlog.size() ? wlog[0].len : -1, WE);
        end
    endtask

    task automatic test_same_cycle();
        logic [AW-1:0] n;
        n = AW'($urandom_range(0, 1000));
        pulse_load(n);
        wait_cyc(3);
        clr_logs();
        @(negedge CLOCK);
        WR_REQ = 2'b11;
        WR_DATA = 16'h2211;
        @(negedge CLOCK);
        WR_REQ = '0;
        wait_cyc(14);
        checks++;
        if (wlog.size() != 2 || wlog[0].a !== n || wlog[0].d !== 8'h11
            || wlog[1].a !== n + 1'b1 || wlog[1].d !== 8'h22) begin
            failures++;
            $display("FAIL same_cycle_log: entries=%0d want 2 (11@%h then 22@next)", wlog.size(), n);
        end
        checks++;
        if (ackq.size() != 2 || ackq[0] != 0 || ackq[1] != 1) begin
            failures++;
            $display("FAIL same_cycle_ack_order: acks=%0d want order 0,1", ackq.size());
        end
        checks++;
        if (OVERRUN !== 1'b0 || SRAM_A !== n + 2'd2) begin
            failures++;
            $display("FAIL same_cycle_state: OVR=%b A=%h want 0 %h", OVERRUN, SRAM_A, n + 2'd2);
        end
    endtask

    task automatic test_overrun();
        pulse_load(19'h00200);
        wait_cyc(3);
        clr_logs();
        @(negedge CLOCK);
        WR_REQ = 2'b01;
        WR_DATA = 16'h0033;
        @(negedge CLOCK);
        WR_REQ = 2'b10;
        WR_DATA[15:8] = 8'h44;
        @(negedge CLOCK);
        WR_DATA[15:8] = 8'h55;
        @(negedge CLOCK);
        WR_REQ = '0;
        wait_cyc(14);
        checks++;
        if (wlog.size() != 2 || wlog[0].d !== 8'h33 || wlog[1].d !== 8'h55
            || wlog[1].a !== 19'h00201 || ackq.size() != 2) begin
            failures++;
            $display("FAIL overrun_log: entries=%0d acks=%0d want 2 writes (33,55) 2 acks",
                     wlog.size(), ackq.size());
        end
        checks++;
        if (OVERRUN !== 1'b1) begin
            failures++;
            $display("FAIL overrun_flag: got %b want 1", OVERRUN);
        end
        pulse_load(19'h00000);
        wait_cyc(3);
        checks++;
        if (OVERRUN !== 1'b0) begin
            failures++;
            $display("FAIL overrun_clear: got %b want 0", OVERRUN);
        end
    endtask

    task automatic test_saturate();
        WRAP_EN = 1'b0;
        pulse_load(AMAX);
        wait_cyc(3);
        clr_logs();
        pulse_wr(0, 8'h5A);
        wait_cyc(8);
        checks++;
        if (wlog.size() != 1 || wlog[0].a !== AMAX || wlog[0].d !== 8'h5A
            || FULL !== 1'b1 || SRAM_A !== AMAX || OVERRUN !== 1'b0) begin
            failures++;
            $display("FAIL saturate_first: writes=%0d FULL=%b A=%h OVR=%b want 1 1 7ffff 0",
                     wlog.size(), FULL, SRAM_A, OVERRUN);
        end
        clr_logs();
        pulse_wr(1, 8'h77);
        wait_cyc(8);
        checks++;
        if (wlog.size() != 0 || ackq.size() != 1 || OVERRUN !== 1'b1 || SRAM_A !== AMAX) begin
            failures++;
            $display("FAIL saturate_drop: writes=%0d acks=%0d OVR=%b A=%h want 0 1 1 7ffff",
                     wlog.size(), ackq.size(), OVERRUN, SRAM_A);
        end
        pulse_load(19'h00000);
        wait_cyc(3);
        checks++;
        if (FULL !== 1'b0 || OVERRUN !== 1'b0 || EMPTY !== 1'b1) begin
            failures++;
            $display("FAIL saturate_clear: FULL=%b OVR=%b EMPTY=%b want 0 0 1", FULL, OVERRUN, EMPTY);
        end
    endtask

    task automatic test_wrap();
        WRAP_EN = 1'b1;
        pulse_load(AMAX);
        wait_cyc(3);
        pulse_wr(0, 8'h3C);
        wait_cyc(8);
        checks++;
        if (SRAM_A !== '0 || EMPTY !== 1'b1 || FULL !== 1'b0) begin
            failures++;
            $display("FAIL wrap: A=%h EMPTY=%b FULL=%b want 0 1 0", SRAM_A, EMPTY, FULL);
        end
    endtask

    task automatic test_reset_mid_write();
        pulse_load(19'h00055);
        wait_cyc(3);
        clr_logs();
        pulse_wr(1, 8'h99);
        wait_cyc(2);
        checks++;
        if (SRAM_WE_n !== 1'b0) begin
            failures++;
            $display("FAIL midwrite_pre: WE_n=%b want 0", SRAM_WE_n);
        end
        #2 RESET_n = 1'b0;
        #1;
        checks++;
        if ({SRAM_A, SRAM_DQ_OUT, SRAM_WE_n, SRAM_OE_n, WR_ACK, BUSY, FULL, OVERRUN, EMPTY}
            !== {{AW{1'b0}}, {DW{1'b0}}, 1'b1, 1'b0, {NC{1'b0}}, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL midwrite_reset: A=%h DQ=%h WE=%b OE=%b ACK=%b BUSY=%b",
                     SRAM_A, SRAM_DQ_OUT, SRAM_WE_n, SRAM_OE_n, WR_ACK, BUSY);
        end
        wait_cyc(2);
        RESET_n = 1'b1;
        wait_cyc(8);
        checks++;
        if (ackq.size() != 0 || BUSY !== 1'b0 || SRAM_A !== '0) begin
            failures++;
            $display("FAIL midwrite_after: acks=%0d BUSY=%b A=%h want 0 0 0", ackq.size(), BUSY, SRAM_A);
        end
        clr_logs();
    endtask

    task automatic test_load_during_write();
        pulse_load(19'h00020);
        wait_cyc(3);
        clr_logs();
        pulse_wr(0, 8'hC3);
        wait_cyc(2);
        ADDR_LOAD = 1'b1;
        ADDR_LOAD_VAL = 19'h00100;
        @(negedge CLOCK);
        ADDR_LOAD = 1'b0;
        wait_cyc(6);
        checks++;
        if (wlog.size() != 1 || wlog[0].a !== 19'h00020 || SRAM_A !== 19'h00100) begin
            failures++;
            $display("FAIL load_in_write: writes=%0d A=%h want 1 00100", wlog.size(), SRAM_A);
        end
        pulse_inc();
        wait_cyc(3);
        checks++;
        if (SRAM_A !== 19'h00101) begin
            failures++;
            $display("FAIL load_then_inc: A=%h want 00101", SRAM_A);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] m_addr;
        logic m_full, m_ovr;
        pulse_load(19'h00000);
        wait_cyc(3);
        m_addr = '0;
        m_full = 1'b0;
        m_ovr = 1'b0;
        for (int n = 0; n < 60; n++) begin
            int op, ch;
            logic [DW-1:0] d;
            logic [AW-1:0] v;
            logic exp_wr;
            exp_wr = 1'b0;
            op = $urandom_range(0, 3);
            ch = $urandom_range(0, NC - 1);
            d = DW'($urandom);
            WRAP_EN = $urandom_range(0, 1) == 1;
            clr_logs();
            if (op == 0) begin
                v = ($urandom_range(0, 1) == 1) ? AMAX - AW'($urandom_range(0, 2)) : AW'($urandom);
                pulse_load(v);
                m_addr = v;
                m_full = 1'b0;
                m_ovr = 1'b0;
            end else if (op == 1) begin
                pulse_inc();
                if (m_addr == AMAX) begin
                    if (WRAP_EN) m_addr = '0;
                    else m_full = 1'b1;
                end else m_addr = m_addr + 1'b1;
            end else begin
                pulse_wr(ch, d);
                if (m_full && !WRAP_EN) m_ovr = 1'b1;
                else exp_wr = 1'b1;
                v = m_addr;
                if (m_addr == AMAX) begin
                    if (WRAP_EN) m_addr = '0;
                    else m_full = 1'b1;
                end else m_addr = m_addr + 1'b1;
            end
            wait_cyc(8);
            checks++;
            if (SRAM_A !== m_addr || FULL !== m_full || OVERRUN !== m_ovr
                || EMPTY !== (m_addr == '0 && !m_full)) begin
                failures++;
                $display("FAIL rand_state[%0d] op=%0d: A=%h F=%b O=%b E=%b want %h %b %b %b",
                         n, op, SRAM_A, FULL, OVERRUN, EMPTY, m_addr, m_full, m_ovr,
                         (m_addr == '0 && !m_full));
            end
            if (op >= 2) begin
                checks++;
                if (wlog.size() != int'(exp_wr) || ackq.size() != 1 || ackq[0] != ch
                    || (exp_wr && (wlog[0].a !== v || wlog[0].d !== d || wlog[0].len != WE))) begin
                    failures++;
                    $display("FAIL rand_write[%0d]: writes=%0d acks=%0d want %0d 1 (ch%0d %h@%h)",
                             n, wlog.size(), ackq.size(), exp_wr, ch, d, v);
                end
            end
        end
        checks++;
        if (unstable != 0) begin
            failures++;
            $display("FAIL bus_stable: %0d unstable WRITE cycles, want 0", unstable);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_same_cycle();
        test_overrun();
        test_saturate();
        test_wrap();
        test_reset_mid_write();
        test_load_during_write();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
